// File: rtl/serial_word_feeder.sv
// Word FIFO feeding a serialiser: pops a word, pulses o_start, then paces per-bit frequency selects.
// Optional sticky write-when-full flag enabled by defining SERIAL_FEEDER_OVERFLOW_EN.
module serial_word_feeder #(
    parameter int unsigned DATA_BIT  = 16,
    parameter int unsigned LOW_FREQ  = 20,
    parameter int unsigned HIGH_FREQ = 10,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [DATA_BIT-1:0]       i_wr_data,
    input  logic [DATA_BIT-1:0]       i_wr_freq_mask,
    input  logic                      i_go,
    input  logic                      i_abort,
    input  logic                      i_done_tick,
    output logic                      o_start,
    output logic                      o_stop,
    output logic [DATA_BIT-1:0]       o_data,
    output logic                      o_sel_freq,
    output logic                      o_empty,
    output logic                      o_full,
    output logic                      o_busy,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_overflow
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned BW   = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam int unsigned MaxP = (LOW_FREQ > HIGH_FREQ) ? LOW_FREQ : HIGH_FREQ;
    localparam int unsigned CW   = (MaxP > 1) ? $clog2(MaxP) : 1;

    localparam logic [AW:0]   FullLevel = DEPTH[AW:0];
    localparam logic [BW-1:0] LastBit   = BW'(DATA_BIT - 1);
    localparam logic [CW-1:0] LowLast   = CW'(LOW_FREQ - 1);
    localparam logic [CW-1:0] HighLast  = CW'(HIGH_FREQ - 1);

    typedef enum logic [1:0] {StIdle, StStart, StSend, StWaitDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_BIT-1:0]   word_q, word_d;
    logic [DATA_BIT-1:0]   mask_q, mask_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  stop_q, stop_d;

    logic [2*DATA_BIT-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  empty, full, push, pop;
    logic [CW-1:0]         period_last;
    logic                  last_bit;
    logic [BW-1:0]         next_bit;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullLevel);
    // Abort flushes this cycle, so neither a write nor a pop may land.
    assign push  = i_wr_en & ~full & ~i_abort;
    assign pop   = (state_q == StIdle) & i_go & ~empty & ~i_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {i_wr_freq_mask, i_wr_data};
    end

    assign period_last = mask_q[bit_q] ? HighLast : LowLast;
    assign last_bit    = (bit_q == LastBit);
    assign next_bit    = bit_q + BW'(1);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mask_d  = mask_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        stop_d  = 1'b0;
        if (i_abort) begin
            state_d = StIdle;
            stop_d  = (state_q != StIdle);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_d          = StStart;
                        {mask_d, word_d} = mem_q[rd_ptr_q];
                    end
                end
                StStart: begin
                    state_d = StSend;
                    bit_d   = '0;
                    cnt_d   = '0;
                end
                StSend: begin
                    if (cnt_q == period_last) begin
                        cnt_d = '0;
                        if (last_bit) state_d = StWaitDone;
                        else          bit_d   = next_bit;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StWaitDone: begin
                    if (i_done_tick) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            mask_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
        end
    end

    // During bit k the serialiser is told the frequency of bit k+1 ahead of time.
    always_comb begin
        o_sel_freq = 1'b0;
        unique case (state_q)
            StStart: o_sel_freq = mask_q[0];
            StSend:  o_sel_freq = last_bit ? 1'b0 : mask_q[next_bit];
            default: o_sel_freq = 1'b0;
        endcase
    end

    assign o_start = (state_q == StStart);
    assign o_busy  = (state_q != StIdle);
    assign o_stop  = stop_q;
    assign o_data  = word_q;
    assign o_empty = empty;
    assign o_full  = full;
    assign o_level = count_q;

`ifdef SERIAL_FEEDER_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  ovf_q <= 1'b0;
        else if (i_abort)         ovf_q <= 1'b0;
        else if (i_wr_en && full) ovf_q <= 1'b1;
    end

    assign o_overflow = ovf_q;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// Randomised bench for serial_word_feeder against a queue/trace reference model.
// Overflow expectations follow SERIAL_FEEDER_OVERFLOW_EN.
module tb_serial_word_feeder;

    localparam int unsigned DW = 16;
    localparam int unsigned LF = 20;
    localparam int unsigned HF = 10;
    localparam int unsigned DP = 4;
    localparam int unsigned LW = $clog2(DP) + 1;
`ifdef SERIAL_FEEDER_OVERFLOW_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_wr_en = 1'b0;
    logic [DW-1:0] i_wr_data = '0;
    logic [DW-1:0] i_wr_freq_mask = '0;
    logic          i_go = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_done_tick = 1'b0;
    logic          o_start, o_stop, o_sel_freq, o_empty, o_full, o_busy, o_overflow;
    logic [DW-1:0] o_data;
    logic [LW-1:0] o_level;

    serial_word_feeder #(
        .DATA_BIT (DW),
        .LOW_FREQ (LF),
        .HIGH_FREQ(HF),
        .DEPTH    (DP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (i_wr_en),
        .i_wr_data     (i_wr_data),
        .i_wr_freq_mask(i_wr_freq_mask),
        .i_go          (i_go),
        .i_abort       (i_abort),
        .i_done_tick   (i_done_tick),
        .o_start       (o_start),
        .o_stop        (o_stop),
        .o_data        (o_data),
        .o_sel_freq    (o_sel_freq),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_busy        (o_busy),
        .o_level       (o_level),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO as queues, a transfer as a per-cycle trace of expected outputs.
    logic [DW-1:0] fq_d[$];
    logic [DW-1:0] fq_m[$];
    bit            tr_st[$];
    bit            tr_sel[$];
    bit            busy_m, stop_m, ovf_m;
    logic [DW-1:0] word_m;

    int cyc = 0;
    int n_start = 0;
    int last_start = 0;
    int prev_start = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fq_d.delete();
        fq_m.delete();
        tr_st.delete();
        tr_sel.delete();
        busy_m = 1'b0;
        stop_m = 1'b0;
        ovf_m  = 1'b0;
        word_m = '0;
    endtask

    task automatic start_transfer(input logic [DW-1:0] d, input logic [DW-1:0] m);
        word_m = d;
        busy_m = 1'b1;
        tr_st.push_back(1'b1);
        tr_sel.push_back(m[0]);
        for (int k = 0; k < DW; k++) begin
            int unsigned p;
            bit nxt;
            p   = m[k] ? HF : LF;
            nxt = (k < DW - 1) ? m[k+1] : 1'b0;
            for (int j = 0; j < int'(p); j++) begin
                tr_st.push_back(1'b0);
                tr_sel.push_back(nxt);
            end
        end
    endtask

    task automatic model_clock(input bit wr, input logic [DW-1:0] d, input logic [DW-1:0] m,
                               input bit go, input bit ab, input bit dn);
        bit was_full;
        was_full = (fq_d.size() == DP);
        stop_m   = ab && busy_m;
        if (ab) begin
            busy_m = 1'b0;
            tr_st.delete();
            tr_sel.delete();
            fq_d.delete();
            fq_m.delete();
            ovf_m = 1'b0;
        end else begin
            if (!busy_m) begin
                if (go && fq_d.size() > 0) begin
                    logic [DW-1:0] hd, hm;
                    hd = fq_d.pop_front();
                    hm = fq_m.pop_front();
                    start_transfer(hd, hm);
                end
            end else if (tr_st.size() > 0) begin
                tr_st.delete(0);
                tr_sel.delete(0);
            end else if (dn) begin
                busy_m = 1'b0;
            end
            if (wr) begin
                if (was_full) begin
                    if (OvfEn) ovf_m = 1'b1;
                end else begin
                    fq_d.push_back(d);
                    fq_m.push_back(m);
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        bit exp_start, exp_sel;
        exp_start = 1'b0;
        exp_sel   = 1'b0;
        if (busy_m && tr_st.size() > 0) begin
            exp_start = tr_st[0];
            exp_sel   = tr_sel[0];
        end
        check_eq({where, ":start"}, 32'(o_start), 32'(exp_start));
        check_eq({where, ":sel"}, 32'(o_sel_freq), 32'(exp_sel));
        check_eq({where, ":busy"}, 32'(o_busy), 32'(busy_m));
        check_eq({where, ":stop"}, 32'(o_stop), 32'(stop_m));
        check_eq({where, ":data"}, 32'(o_data), 32'(word_m));
        check_eq({where, ":level"}, 32'(o_level), 32'(fq_d.size()));
        check_eq({where, ":empty"}, 32'(o_empty), 32'(fq_d.size() == 0));
        check_eq({where, ":full"}, 32'(o_full), 32'(fq_d.size() == DP));
        check_eq({where, ":ovf"}, 32'(o_overflow), 32'(ovf_m));
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] d, input logic [DW-1:0] m,
                        input bit go, input bit ab, input bit dn);
        i_wr_en        = wr;
        i_wr_data      = d;
        i_wr_freq_mask = m;
        i_go           = go;
        i_abort        = ab;
        i_done_tick    = dn;
        model_clock(wr, d, m, go, ab, dn);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (o_start === 1'b1) begin
            n_start++;
            prev_start = last_start;
            last_start = cyc;
        end
        check_all("step");
    endtask

    // Asynchronous reset asserted between clock edges; outputs are checked before any edge.
    task automatic do_reset();
        i_wr_en     = 1'b0;
        i_go        = 1'b0;
        i_abort     = 1'b0;
        i_done_tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst = 1'b0;
        check_all("rst_rel");
    endtask

    initial begin
        int len;
        bit seen;
        int s0;
        bit go_r;

        model_reset();
        @(negedge clk);
        check_all("por");
        rst = 1'b0;

        // Plain word, all-low frequency: START + 320 SEND + 1 WAIT_DONE with done held high.
        do_reset();
        step(1'b1, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b0);
        len = 0; seen = 1'b0; s0 = n_start;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
            if (o_busy) begin seen = 1'b1; len++; end
            else if (seen) break;
        end
        check_eq("a5_busy_len", len, 322);
        check_eq("a5_starts", n_start - s0, 1);

        // Two high-frequency bits: SEND shrinks to 300 cycles.
        do_reset();
        step(1'b1, 16'h1234, 16'h0003, 1'b0, 1'b0, 1'b0);
        len = 0; seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
            if (o_busy) begin seen = 1'b1; len++; end
            else if (seen) break;
        end
        check_eq("m3_busy_len", len, 302);

        // Fill with go low: fifth write dropped.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h100 + i), '0, 1'b0, 1'b0, 1'b0);
        check_eq("fill_level", o_level, DP);
        check_eq("fill_full", o_full, 1);
        check_eq("fill_ovf", o_overflow, OvfEn);
        for (int i = 0; i < DP + 1; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
            for (int j = 0; j < 400 && o_busy; j++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        check_eq("fill_drained", o_level, 0);

        // Back-to-back: second START exactly 2 cycles after the accepted done tick.
        do_reset();
        step(1'b1, 16'h1111, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, '0, 1'b0, 1'b0, 1'b0);
        s0 = n_start;
        for (int i = 0; i < 1000 && (n_start - s0) < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("b2b_starts", n_start - s0, 2);
        check_eq("b2b_gap", last_start - prev_start, 323);

        // Abort during bit 5 with two words queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(16'hC0 + i), '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 111; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("abort_pre_busy", o_busy, 1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("abort_stop", o_stop, 1);
        check_eq("abort_level", o_level, 0);
        check_eq("abort_busy", o_busy, 0);
        s0 = n_start;
        for (int i = 0; i < 40; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("abort_no_start", n_start - s0, 0);

        // Reset mid-SEND: no stop pulse afterwards.
        do_reset();
        step(1'b1, 16'hBEEF, DW'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("rst_pre_busy", o_busy, 1);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Random traffic, including stray done ticks, full writes and rare aborts.
        go_r = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 199) == 0) go_r = ~go_r;
            step($urandom_range(0, 29) == 0, DW'($urandom), DW'($urandom), go_r,
                 $urandom_range(0, 1499) == 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 The block SHALL have parameter DATA_BIT, default 16, meaning the word width and bits per serial transfer.
REQ-002 The block SHALL have parameter LOW_FREQ, default 20, meaning the low-frequency bit period in clk cycles.
REQ-003 The block SHALL have parameter HIGH_FREQ, default 10, meaning the high-frequency bit period in clk cycles.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the word FIFO depth (power of two, at least 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_wr_en, input, 1 bit: FIFO write strobe.
REQ-008 The block SHALL have port i_wr_data, input, DATA_BIT bits: the word to serialise.
REQ-009 The block SHALL have port i_wr_freq_mask, input, DATA_BIT bits: per-bit frequency select, where bit k=1 means bit k uses HIGH_FREQ.
REQ-010 The block SHALL have port i_go, input, 1 bit: a level enable that allows new transfers to start.
REQ-011 The block SHALL have port i_abort, input, 1 bit: cancels the current transfer and flushes the FIFO.
REQ-012 The block SHALL have port i_done_tick, input, 1 bit: the done pulse from the downstream serialiser.
REQ-013 The block SHALL have port o_start, output, 1 bit: a one-cycle start pulse to the serialiser.
REQ-014 The block SHALL have port o_stop, output, 1 bit: a one-cycle stop pulse to the serialiser.
REQ-015 The block SHALL have port o_data, output, DATA_BIT bits: the word being sent.
REQ-016 The block SHALL have port o_sel_freq, output, 1 bit: the frequency select to the serialiser.
REQ-017 The block SHALL have ports o_empty, o_full, o_busy, output, 1 bit each: FIFO and transfer status.
REQ-018 The block SHALL have port o_level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-019 The block SHALL have port o_overflow, output, 1 bit: sticky write-when-full flag.

Function
REQ-020 The FSM SHALL have states IDLE, START, SEND and WAIT_DONE; o_busy SHALL be 1 in every state except IDLE.
REQ-021 In IDLE, when i_go=1 and o_empty=0, the FSM SHALL move to START; the FIFO head SHALL be popped on that transition.
REQ-022 In START (exactly one cycle), the block SHALL drive o_start=1, o_data=the popped word and o_sel_freq=mask[0], then move to SEND with bit index k=0 and cycle counter 0.
REQ-023 In SEND, bit k SHALL last P_k cycles, where P_k=HIGH_FREQ if mask[k]=1 and LOW_FREQ otherwise; the counter runs 0..P_k-1, then k increments.
REQ-024 While in bit k of SEND, o_sel_freq SHALL equal mask[k+1] for k<DATA_BIT-1 and 0 for the last bit, including on the boundary cycle, so the downstream samples the next bit's frequency correctly.
REQ-025 At the end of bit DATA_BIT-1, the FSM SHALL move to WAIT_DONE.
REQ-026 In WAIT_DONE, i_done_tick=1 SHALL return the FSM to IDLE; an i_done_tick pulse outside WAIT_DONE SHALL be ignored.
REQ-027 o_data SHALL hold the current word from START until the next START.
REQ-028 Back-to-back words SHALL give o_start exactly 2 cycles after i_done_tick; the downstream idle mode SHALL NOT be REPEAT.
REQ-029 i_abort=1 in any non-IDLE state SHALL give o_stop=1 in the next cycle for one cycle, return the FSM to IDLE, and flush the FIFO to level 0.
REQ-030 i_abort=1 in IDLE SHALL flush the FIFO and SHALL NOT pulse o_stop.
REQ-031 A write in the same cycle as an abort flush SHALL be discarded.
REQ-032 A write when o_full=1 SHALL be dropped without changing the FIFO contents.
REQ-033 A write and a pop in the same cycle SHALL both take effect, leaving o_level unchanged.
REQ-034 i_go falling during a transfer SHALL NOT interrupt that transfer; it only blocks the next START.

Reset
REQ-035 While rst=1, the block SHALL hold state=IDLE, FIFO level 0, o_start=0, o_stop=0, o_data=0, o_sel_freq=0, o_busy=0, o_empty=1, o_full=0 and o_overflow=0.
REQ-036 rst asserted mid-transfer SHALL abandon the word immediately and SHALL NOT pulse o_stop.

Configuration
REQ-037 With SERIAL_FEEDER_OVERFLOW_EN defined, a write when o_full=1 SHALL set o_overflow=1, which stays set until rst or an abort flush.
REQ-038 Without SERIAL_FEEDER_OVERFLOW_EN, o_overflow SHALL be tied to 0 and no overflow register SHALL exist.

Verification
REQ-039 Write 0xA5A5 with mask 0x0000 and i_go=1: one o_start with o_data=0xA5A5; o_sel_freq=0 throughout; WAIT_DONE entered 320 cycles after SEND entry.
REQ-040 Write mask 0x0003: o_sel_freq=1 in START; bit0 lasts 10 cycles with o_sel_freq=1; bit1 lasts 10 cycles with o_sel_freq=0; total SEND time 300 cycles.
REQ-041 Five writes with i_go=0 and the macro on: o_full=1 after the 4th write; the 5th is dropped; o_level=4; o_overflow=1.
REQ-042 Two queued words with i_done_tick returned in WAIT_DONE: the second o_start occurs exactly 2 cycles after i_done_tick.
REQ-043 i_abort during bit 5 with 2 words queued: o_stop=1 for one cycle; o_level=0; o_busy=0; no further o_start.
REQ-044 rst asserted mid-SEND: all outputs reach reset values asynchronously, with no o_stop pulse.
